// File: rtl/mux_nto1_reg.sv
// Registered N-channel to 1 stream multiplexer with per-channel valid/ready handshake.
// Channels are granted either by explicit select or by round-robin arbitration.
module mux_nto1_reg #(
    parameter int DATA_W = 4,
    parameter int N_CH   = 4,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   inData,
    input  logic [N_CH-1:0]          inValid,
    output logic [N_CH-1:0]          inReady,
    input  logic [SEL_W-1:0]         inSel,
    input  logic                     inMode,
    output logic [DATA_W-1:0]        outData,
    output logic [SEL_W-1:0]         outChan,
    output logic                     outValid,
    input  logic                     outReady
);

    logic              load_en;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt;
    logic [SEL_W-1:0]  rr_ptr;
    logic [DATA_W-1:0] gnt_data;
    int                cand;

    // The output register may take a new beat when empty or when being drained.
    assign load_en = !outValid || outReady;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        cand    = 0;
        if (!inMode) begin
            // Out-of-range selects never match a channel, so they are never granted.
            for (int k = 0; k < N_CH; k++) begin
                if (inSel == SEL_W'(k) && inValid[k]) begin
                    gnt     = SEL_W'(k);
                    gnt_vld = 1'b1;
                end
            end
        end else begin
            // Scan from the channel after the last grant, wrapping modulo N_CH.
            for (int off = 1; off <= N_CH; off++) begin
                cand = int'(rr_ptr) + off;
                if (cand >= N_CH) begin
                    cand = cand - N_CH;
                end
                if (!gnt_vld && inValid[cand]) begin
                    gnt     = SEL_W'(cand);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt == SEL_W'(k)) begin
                gnt_data = inData[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        inReady = '0;
        if (!rst && load_en && gnt_vld) begin
            for (int k = 0; k < N_CH; k++) begin
                if (gnt == SEL_W'(k)) begin
                    inReady[k] = 1'b1;
                end
            end
        end
    end

    // Output register stage; reset leaves the pointer so the next scan starts at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid <= 1'b0;
            outData  <= '0;
            outChan  <= '0;
            rr_ptr   <= SEL_W'(N_CH - 1);
        end else if (load_en) begin
            if (gnt_vld) begin
                outData  <= gnt_data;
                outChan  <= gnt;
                outValid <= 1'b1;
                rr_ptr   <= gnt;
            end else begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: a 4-channel and a 3-channel instance checked every cycle
// against a behavioural model, plus directed scenarios with literal expectations.
module tb_mux_nto1_reg;

    logic        clk;
    logic        rst_a, rst_b;

    logic [15:0] a_data;
    logic [3:0]  a_valid, a_ready;
    logic [1:0]  a_sel, a_chan;
    logic        a_mode, a_ov, a_or;
    logic [3:0]  a_out;

    logic [11:0] b_data;
    logic [2:0]  b_valid, b_ready;
    logic [1:0]  b_sel, b_chan;
    logic        b_mode, b_ov, b_or;
    logic [3:0]  b_out;

    int vectors = 0;
    int errors  = 0;

    mux_nto1_reg #(.DATA_W(4), .N_CH(4)) dut_a (
        .clk(clk), .rst(rst_a), .inData(a_data), .inValid(a_valid), .inReady(a_ready),
        .inSel(a_sel), .inMode(a_mode), .outData(a_out), .outChan(a_chan),
        .outValid(a_ov), .outReady(a_or)
    );

    mux_nto1_reg #(.DATA_W(4), .N_CH(3)) dut_b (
        .clk(clk), .rst(rst_b), .inData(b_data), .inValid(b_valid), .inReady(b_ready),
        .inSel(b_sel), .inMode(b_mode), .outData(b_out), .outChan(b_chan),
        .outValid(b_ov), .outReady(b_or)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state, index 0 = 4-channel instance, 1 = 3-channel instance.
    bit m_known[2];
    bit m_vld[2];
    int m_data[2];
    int m_chan[2];
    int m_ptr[2];
    bit n_known[2];
    bit n_vld[2];
    int n_data[2];
    int n_chan[2];
    int n_ptr[2];

    function automatic int grant_of(input int n, input logic mode, input int sel,
                                    input logic [15:0] v, input int ptr);
        if (!mode) return (sel < n && v[sel]) ? sel : -1;
        for (int i = 1; i <= n; i++) begin
            if (v[(ptr + i) % n]) return (ptr + i) % n;
        end
        return -1;
    endfunction

    task automatic eval(input int d, input string nm, input logic r, input logic mode,
                        input int sel, input logic [15:0] v, input logic [31:0] dat,
                        input logic ordy, input logic [3:0] od, input logic [1:0] oc,
                        input logic ov, input logic [15:0] rdy, input int n);
        int g;
        bit load;
        logic [15:0] exp_rdy;
        g = grant_of(n, mode, sel, v, m_ptr[d]);
        load = !m_vld[d] || ordy;
        if (m_known[d]) begin
            exp_rdy = (!r && load && g >= 0) ? (16'(1) << g) : 16'h0;
            chk({nm, "_outValid"}, {31'b0, ov}, {31'b0, m_vld[d]});
            chk({nm, "_outData"}, {28'b0, od}, m_data[d]);
            chk({nm, "_outChan"}, {30'b0, oc}, m_chan[d]);
            chk({nm, "_inReady"}, {16'b0, rdy}, {16'b0, exp_rdy});
        end
        n_known[d] = m_known[d];
        n_vld[d] = m_vld[d]; n_data[d] = m_data[d]; n_chan[d] = m_chan[d]; n_ptr[d] = m_ptr[d];
        if (r) begin
            n_known[d] = 1'b1;
            n_vld[d] = 1'b0; n_data[d] = 0; n_chan[d] = 0; n_ptr[d] = n - 1;
        end else if (m_known[d] && load) begin
            if (g >= 0) begin
                n_vld[d] = 1'b1; n_data[d] = (dat >> (g * 4)) & 32'hF;
                n_chan[d] = g; n_ptr[d] = g;
            end else begin
                n_vld[d] = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            eval(0, "n4", rst_a, a_mode, int'(a_sel), {12'b0, a_valid}, {16'b0, a_data},
                 a_or, a_out, a_chan, a_ov, {12'b0, a_ready}, 4);
            eval(1, "n3", rst_b, b_mode, int'(b_sel), {13'b0, b_valid}, {20'b0, b_data},
                 b_or, b_out, b_chan, b_ov, {13'b0, b_ready}, 3);
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                m_known[d] = n_known[d]; m_vld[d] = n_vld[d]; m_data[d] = n_data[d];
                m_chan[d] = n_chan[d]; m_ptr[d] = n_ptr[d];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_c[5] = '{0, 1, 2, 3, 0};
    int rr_d[5] = '{1, 2, 3, 4, 1};
    int sp_c[4] = '{0, 3, 0, 3};
    int b_c[4]  = '{0, 1, 2, 0};
    int b_d[4]  = '{1, 2, 3, 1};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_data = '0; a_valid = '0; a_sel = '0; a_mode = 1'b0; a_or = 1'b1;
        b_data = '0; b_valid = '0; b_sel = '0; b_mode = 1'b0; b_or = 1'b1;
        repeat (2) tick();
        chk("reset_outValid", {31'b0, a_ov}, 32'd0);
        chk("reset_inReady", {28'b0, a_ready}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        // explicit select of channel 2
        a_mode = 1'b0; a_sel = 2'd2; a_valid = 4'b0100; a_data = 16'h0A00; a_or = 1'b1;
        #1 chk("sel_inReady", {28'b0, a_ready}, 32'h4);
        tick(); a_valid = 4'b0000;
        chk("sel_outData", {28'b0, a_out}, 32'hA);
        chk("sel_outChan", {30'b0, a_chan}, 32'd2);
        chk("sel_outValid", {31'b0, a_ov}, 32'd1);

        // backpressure hold, then reload without a bubble
        tick(); a_valid = 4'b0100; a_data = 16'h0B00;
        tick(); a_or = 1'b0; a_data = 16'h0C00;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin tick(); a_data = 16'h0E00 + 16'(i); end
            #1 chk("hold_inReady", {28'b0, a_ready}, 32'd0);
            chk("hold_outData", {28'b0, a_out}, 32'hB);
            chk("hold_outValid", {31'b0, a_ov}, 32'd1);
        end
        tick(); a_or = 1'b1; a_data = 16'h0D00;
        #1 chk("drain_inReady", {28'b0, a_ready}, 32'h4);
        tick(); a_valid = 4'b0000;
        chk("nobubble_outData", {28'b0, a_out}, 32'hD);
        chk("nobubble_outValid", {31'b0, a_ov}, 32'd1);

        // round-robin, all channels valid
        tick(); rst_a = 1'b1;
        tick(); rst_a = 1'b0; a_mode = 1'b1; a_valid = 4'hF; a_data = 16'h4321;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_outChan", {30'b0, a_chan}, rr_c[i]);
            chk("rr_outData", {28'b0, a_out}, rr_d[i]);
        end

        // round-robin, sparse valid
        tick(); rst_a = 1'b1;
        tick(); rst_a = 1'b0; a_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_sparse_outChan", {30'b0, a_chan}, sp_c[i]);
        end

        // three channels, wrap at 2
        tick(); rst_b = 1'b1;
        tick(); rst_b = 1'b0; b_mode = 1'b1; b_valid = 3'b111; b_data = 12'h321; b_or = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr3_outChan", {30'b0, b_chan}, b_c[i]);
            chk("rr3_outData", {28'b0, b_out}, b_d[i]);
        end

        // select of an idle channel
        tick(); a_mode = 1'b0; a_sel = 2'd1; a_valid = 4'b1101;
        #1 chk("selmiss_inReady", {28'b0, a_ready}, 32'd0);
        tick();
        chk("selmiss_outValid", {31'b0, a_ov}, 32'd0);

        // out-of-range select on three channels
        tick(); b_mode = 1'b0; b_sel = 2'd3; b_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1 chk("oor_inReady", {29'b0, b_ready}, 32'd0);
            tick();
            chk("oor_outValid", {31'b0, b_ov}, 32'd0);
        end

        // reset while a beat is held
        tick(); a_mode = 1'b0; a_sel = 2'd1; a_valid = 4'b0010; a_data = 16'h0050; a_or = 1'b1;
        tick(); a_valid = 4'b0000; a_or = 1'b0;
        chk("held_outData", {28'b0, a_out}, 32'h5);
        chk("held_outChan", {30'b0, a_chan}, 32'd1);
        tick(); rst_a = 1'b1;
        chk("held_outValid", {31'b0, a_ov}, 32'd1);
        tick(); rst_a = 1'b0; a_mode = 1'b1; a_valid = 4'hF; a_data = 16'h4321; a_or = 1'b1;
        chk("rstmid_outValid", {31'b0, a_ov}, 32'd0);
        chk("rstmid_outData", {28'b0, a_out}, 32'd0);
        tick();
        chk("rstmid_rr_outChan", {30'b0, a_chan}, 32'd0);
        chk("rstmid_rr_outData", {28'b0, a_out}, 32'd1);

        // randomized traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst_a   = ($urandom_range(0, 63) == 0);
            a_mode  = 1'($urandom);
            a_sel   = 2'($urandom);
            a_valid = 4'($urandom);
            a_data  = 16'($urandom);
            a_or    = ($urandom_range(0, 3) != 0);
            rst_b   = ($urandom_range(0, 63) == 0);
            b_mode  = 1'($urandom);
            b_sel   = 2'($urandom);
            b_valid = 3'($urandom);
            b_data  = 12'($urandom);
            b_or    = ($urandom_range(0, 3) != 0);
        end
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mux_nto1_reg.md
Name: mux_nto1_reg

Overview:
- Parametrised, registered N-channel to 1 stream multiplexer for the baseband datapath.
- Generalises the fixed 2:1, 4:1 and 8:1 combinational MUX cells by adding:
  - width and channel-count parameters;
  - a per-channel valid/ready handshake;
  - a selectable round-robin arbitration mode.
- Sits between parallel chip/symbol sources and a single downstream consumer.
- The output register gives one cycle of latency and full throughput.

Parameters:
- DATA_W, default 4: bits per channel word.
- N_CH, default 4: number of input channels, legal range 2 to 16.
- SEL_W, default $clog2(N_CH): select and channel-index width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- inData  in  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- inValid  in  N_CH  channel k presents a word.
- inReady  out  N_CH  channel k word accepted this cycle.
- inSel  in  SEL_W  channel select, used in select mode only.
- inMode  in  1  0 = explicit select, 1 = round-robin.
- outData  out  DATA_W  registered selected word.
- outChan  out  SEL_W  index of the channel that supplied outData.
- outValid  out  1  outData/outChan hold a beat.
- outReady  in  1  downstream accepts the beat.

Behaviour:
- Reset, while rst=1 at a clk edge:
  - outValid=0, outData=0, outChan=0, rrPtr=N_CH-1.
  - inReady is all-zero during the reset cycle.
- Load enable: loadEn = !outValid || outReady.
- Grant, combinational:
  - Select mode: gnt = inSel if inSel < N_CH and inValid[inSel]=1; otherwise no grant.
  - Out-of-range inSel is never granted.
  - Round-robin mode: scan channels rrPtr+1, rrPtr+2, … modulo N_CH.
  - gnt = the first index with inValid=1; no grant if none are valid.
- Ready: inReady[k] = loadEn && grant valid && gnt==k.
  - At most one bit set.
  - inReady is combinational from outReady, inValid, inSel and inMode; no combinational path to outData.
- Transfer: on an edge with a grant and loadEn, the block loads:
  - outData ← the granted word;
  - outChan ← gnt;
  - outValid ← 1.
- No grant: if loadEn=1 with no grant, then outValid ← 0; outData and outChan keep their last values.
- Hold: while outValid=1 and outReady=0, outData, outChan and outValid stay stable, and inReady is all-zero.
- Throughput:
  - outReady=1 together with a new grant replaces the beat in the same cycle, with no bubble.
  - Result: one beat per clock is sustained.
- rrPtr update:
  - rrPtr ← gnt on every transfer, in either mode, so a switch to round-robin resumes fairly.
  - rrPtr wraps from N_CH-1 to 0.
- inMode and inSel are sampled per cycle.
  - A change affects only the next arbitration.
  - A beat already held in the output register is never altered.
- Latency: an input accepted at edge n appears on outData after edge n; that is 1 cycle.
- Reset mid-operation: any held beat is discarded, with outValid=0 on the next cycle, and round-robin restarts at channel 0.
- Widths: no arithmetic on data. The rrPtr increment is modulo N_CH, not modulo 2^SEL_W; this matters when N_CH is not a power of two.

Test Plan (N_CH=4, DATA_W=4 unless stated):
- Reset, then select mode with inSel=2, inValid=4'b0100, inData=16'h0A00, outReady=1.
  - Next cycle: outData=4'hA, outChan=2, outValid=1.
  - inReady=4'b0100 during the accept cycle.
- Backpressure: a beat is held with outValid=1 and outReady=0 for 3 cycles while inData changes.
  - Required: outData is unchanged, inReady=0.
  - Then outReady=1 with a new grant: the new word loads with no bubble cycle.
- Round-robin after reset with inValid=4'b1111, inData=16'h4321, outReady=1 continuous.
  - Required outChan sequence: 0,1,2,3,0.
  - Required outData sequence: 1,2,3,4,1.
- Round-robin sparse case with inValid=4'b1001 held.
  - Required grants: 0,3,0,3.
  - Re-run with N_CH=3 and inValid=3'b111: required grants 0,1,2,0, with wrap at 2.
- Select mode with inSel=1 and inValid[1]=0 (other channels valid).
  - Required: no grant, outValid falls to 0 once accepted downstream.
  - With N_CH=3 and inSel=3: never granted.
- Assert rst while outValid=1 and outReady=0.
  - Next cycle: outValid=0, outData=0.
  - The following round-robin grant is channel 0.
